perceptron_trainer_fixed: RTL

//  Sequential on-line trainer for one 2-input step-activation neuron, fixed-point data.

---
 rtl/perceptron_trainer_fixed_pkg.sv | 30 +++
 rtl/perceptron_trainer_fixed_if.sv | 30 +++
 rtl/perceptron_trainer_fixed_mac.sv | 25 ++
 rtl/perceptron_trainer_fixed.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/perceptron_trainer_fixed_pkg.sv
// rtl/perceptron_trainer_fixed_pkg.sv - Q3.12 sign-magnitude constants, conversions and trainer states
package perceptron_trainer_fixed_pkg;

  localparam int TAM  = 16;
  localparam int FRAC = 12;
  // Two's complement working width: holds +/-0x7FFF plus one learning step without wrap.
  localparam int TCW  = TAM + 4;
  localparam int NETW = 2 * TCW + 2;

  localparam logic [TAM-1:0] ONE    = 16'h1000;
  localparam logic [TAM-1:0] SM_MAX = 16'h7FFF;

  typedef enum logic [2:0] {IDLE, LOAD, EVAL, UPDATE, CHECK, DONE} trainer_state_t;

  function automatic logic signed [TCW-1:0] sm_to_tc(input logic [TAM-1:0] sm);
    logic signed [TCW-1:0] mag;
    mag = signed'({{(TCW-TAM+1){1'b0}}, sm[TAM-2:0]});
    return sm[TAM-1] ? -mag : mag;
  endfunction

  function automatic logic [TAM-1:0] tc_to_sm_sat(input logic signed [TCW-1:0] v);
    logic [TCW-1:0] mag;
    logic           sat;
    mag = v[TCW-1] ? unsigned'(-v) : unsigned'(v);
    sat = |mag[TCW-1:TAM-1];
    if (mag == '0) return '0;
    return {v[TCW-1], sat ? SM_MAX[TAM-2:0] : mag[TAM-2:0]};
  endfunction

endpackage

// File: rtl/perceptron_trainer_fixed_if.sv
// rtl/perceptron_trainer_fixed_if.sv - training request/result bundle for the perceptron trainer
interface perceptron_trainer_fixed_if;
  import perceptron_trainer_fixed_pkg::*;

  logic                 start;
  logic [3:0][TAM-1:0]  in1;
  logic [3:0][TAM-1:0]  in2;
  logic [3:0][TAM-1:0]  d;
  logic [TAM-1:0]       w0_init;
  logic [TAM-1:0]       w1_init;
  logic [TAM-1:0]       w2_init;
  logic                 busy;
  logic                 done;
  logic                 converged;
  logic [6:0]           epochs;
  logic [TAM-1:0]       w0;
  logic [TAM-1:0]       w1;
  logic [TAM-1:0]       w2;

  modport master (
    output start, in1, in2, d, w0_init, w1_init, w2_init,
    input  busy, done, converged, epochs, w0, w1, w2
  );

  modport slave (
    input  start, in1, in2, d, w0_init, w1_init, w2_init,
    output busy, done, converged, epochs, w0, w1, w2
  );

endinterface

// File: rtl/perceptron_trainer_fixed_mac.sv
// rtl/perceptron_trainer_fixed_mac.sv - combinational neuron net w0 + (w1*x1 + w2*x2)>>>FRAC
module perceptron_trainer_fixed_mac
  import perceptron_trainer_fixed_pkg::*;
(
  input  logic signed [TCW-1:0]  i_w0,
  input  logic signed [TCW-1:0]  i_w1,
  input  logic signed [TCW-1:0]  i_w2,
  input  logic signed [TCW-1:0]  i_x1,
  input  logic signed [TCW-1:0]  i_x2,
  output logic signed [NETW-1:0] o_net
);

  logic signed [2*TCW-1:0] w_p1;
  logic signed [2*TCW-1:0] w_p2;
  logic signed [2*TCW:0]   w_sum;
  logic signed [2*TCW:0]   w_shift;

  assign w_p1    = i_w1 * i_x1;
  assign w_p2    = i_w2 * i_x2;
  assign w_sum   = {w_p1[2*TCW-1], w_p1} + {w_p2[2*TCW-1], w_p2};
  // Products are rescaled once after summing, so rounding happens a single time (floor).
  assign w_shift = w_sum >>> FRAC;
  assign o_net   = {w_shift[2*TCW], w_shift} + {{(NETW-TCW){i_w0[TCW-1]}}, i_w0};

endmodule

// File: rtl/perceptron_trainer_fixed.sv
// rtl/perceptron_trainer_fixed.sv - on-line perceptron-rule trainer for one 2-input step neuron
module perceptron_trainer_fixed
  import perceptron_trainer_fixed_pkg::*;
#(
  parameter int ETA_SHIFT  = 1,
  parameter int MAX_EPOCHS = 64
) (
  input logic                      clk,
  input logic                      rst_n,
  perceptron_trainer_fixed_if.slave bus
);

  localparam logic [6:0]           MAX_EP = 7'(MAX_EPOCHS);
  localparam logic signed [TCW-1:0] ONE_TC = signed'({{(TCW-TAM){1'b0}}, ONE});

  trainer_state_t r_state, w_next;

  logic [3:0][TAM-1:0] r_in1;
  logic [3:0][TAM-1:0] r_in2;
  logic [3:0]          r_t;
  logic [TAM-1:0]      r_w0, r_w1, r_w2;
  logic [1:0]          r_idx;
  logic                r_err;
  logic                r_y;
  logic [6:0]          r_epochs;
  logic                r_busy, r_done, r_conv;

  logic signed [TCW-1:0]  w_w0_tc, w_w1_tc, w_w2_tc, w_x1_tc, w_x2_tc;
  logic signed [TCW-1:0]  w_s0, w_s1, w_s2, w_n0, w_n1, w_n2;
  logic signed [NETW-1:0] w_net;
  logic                   w_y, w_e_pos, w_e_neg, w_last;
  logic [6:0]             w_ep_inc;

  assign w_w0_tc = sm_to_tc(r_w0);
  assign w_w1_tc = sm_to_tc(r_w1);
  assign w_w2_tc = sm_to_tc(r_w2);
  assign w_x1_tc = sm_to_tc(r_in1[r_idx]);
  assign w_x2_tc = sm_to_tc(r_in2[r_idx]);

  perceptron_trainer_fixed_mac u_mac (
    .i_w0  (w_w0_tc),
    .i_w1  (w_w1_tc),
    .i_w2  (w_w2_tc),
    .i_x1  (w_x1_tc),
    .i_x2  (w_x2_tc),
    .o_net (w_net)
  );

  // Step activation: net == 0 classifies as 0.
  assign w_y     = !w_net[NETW-1] && (w_net != '0);
  assign w_e_pos = r_t[r_idx] & ~r_y;
  assign w_e_neg = ~r_t[r_idx] & r_y;

  assign w_s0 = ONE_TC  >>> ETA_SHIFT;
  assign w_s1 = w_x1_tc >>> ETA_SHIFT;
  assign w_s2 = w_x2_tc >>> ETA_SHIFT;
  assign w_n0 = w_e_neg ? (w_w0_tc - w_s0) : (w_w0_tc + w_s0);
  assign w_n1 = w_e_neg ? (w_w1_tc - w_s1) : (w_w1_tc + w_s1);
  assign w_n2 = w_e_neg ? (w_w2_tc - w_s2) : (w_w2_tc + w_s2);

  assign w_ep_inc = r_epochs + 7'd1;
  assign w_last   = (w_ep_inc == MAX_EP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (bus.start) w_next = LOAD;
      LOAD:       w_next = EVAL;
      EVAL:       w_next = UPDATE;
      UPDATE:     w_next = (r_idx == 2'd3) ? CHECK : EVAL;
      CHECK:      w_next = (!r_err || w_last) ? DONE : EVAL;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in1    <= '0;
      r_in2    <= '0;
      r_t      <= '0;
      r_w0     <= '0;
      r_w1     <= '0;
      r_w2     <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
      r_y      <= 1'b0;
      r_epochs <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_conv   <= 1'b0;
    end else begin
      case (r_state)
        LOAD: begin
          r_in1 <= bus.in1;
          r_in2 <= bus.in2;
          for (int i = 0; i < 4; i++) r_t[i] <= ((bus.d[i] & SM_MAX) != '0);
          r_w0     <= bus.w0_init;
          r_w1     <= bus.w1_init;
          r_w2     <= bus.w2_init;
          r_idx    <= '0;
          r_err    <= 1'b0;
          r_epochs <= '0;
          r_conv   <= 1'b0;
          r_done   <= 1'b0;
          r_busy   <= 1'b1;
        end
        EVAL: r_y <= w_y;
        UPDATE: begin
          r_idx <= r_idx + 2'd1;
          if (w_e_pos || w_e_neg) begin
            r_w0  <= tc_to_sm_sat(w_n0);
            r_w1  <= tc_to_sm_sat(w_n1);
            r_w2  <= tc_to_sm_sat(w_n2);
            r_err <= 1'b1;
          end
        end
        CHECK: begin
          r_epochs <= w_ep_inc;
          if (!r_err) begin
            r_conv <= 1'b1;
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else if (w_last) begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end else begin
            r_err <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.converged = r_conv;
  assign bus.epochs    = r_epochs;
  assign bus.w0        = r_w0;
  assign bus.w1        = r_w1;
  assign bus.w2        = r_w2;

endmodule
